// File: rtl/cfg_mgmt_arbiter_if.sv
// ---------------------------------------------------------------------------
// cfg_mgmt_arbiter_if
// Configuration-bridge controller port bundle.
//   ctr2cfg_* : command from the arbiter to the bridge (address, function,
//               write/read strobes, write data, byte enables, debug flag)
//   cfg2ctr_* : completion from the bridge (write/read done, read data)
// Modports:
//   master : arbiter side (drives ctr2cfg_*, receives cfg2ctr_*)
//   slave  : bridge side  (receives ctr2cfg_*, drives cfg2ctr_*)
// ---------------------------------------------------------------------------
interface cfg_mgmt_arbiter_if;
  logic [9:0]  ctr2cfg_mgmt_addr;
  logic [7:0]  ctr2cfg_mgmt_function_number;
  logic        ctr2cfg_mgmt_write;
  logic [31:0] ctr2cfg_mgmt_write_data;
  logic [3:0]  ctr2cfg_mgmt_byte_enable;
  logic        ctr2cfg_mgmt_read;
  logic        ctr2cfg_mgmt_debug_access;
  logic        cfg2ctr_mgmt_write_done;
  logic        cfg2ctr_mgmt_read_done;
  logic [31:0] cfg2ctr_mgmt_read_data;

  modport master (
    output ctr2cfg_mgmt_addr, ctr2cfg_mgmt_function_number, ctr2cfg_mgmt_write,
           ctr2cfg_mgmt_write_data, ctr2cfg_mgmt_byte_enable, ctr2cfg_mgmt_read,
           ctr2cfg_mgmt_debug_access,
    input  cfg2ctr_mgmt_write_done, cfg2ctr_mgmt_read_done, cfg2ctr_mgmt_read_data
  );

  modport slave (
    input  ctr2cfg_mgmt_addr, ctr2cfg_mgmt_function_number, ctr2cfg_mgmt_write,
           ctr2cfg_mgmt_write_data, ctr2cfg_mgmt_byte_enable, ctr2cfg_mgmt_read,
           ctr2cfg_mgmt_debug_access,
    output cfg2ctr_mgmt_write_done, cfg2ctr_mgmt_read_done, cfg2ctr_mgmt_read_data
  );
endinterface

// File: rtl/cfg_mgmt_arbiter.sv
// ---------------------------------------------------------------------------
// cfg_mgmt_arbiter
// Round-robin arbiter sharing one configuration-bridge port between NUM_REQ
// requesters. One command is outstanding at a time; each command ends with a
// matching done from the bridge or with a timeout, followed by GAP idle cycles.
// Ports:
//   user_clk, user_reset_n : clock, async active-low reset (sync release)
//   user_lnk_up            : grant enable
//   req_valid/write/addr/func/wdata/be : packed per-requester requests
//   req_done, rsp_data, rsp_err        : per-transaction completion
//   cfg                    : bridge controller port (master modport)
// ---------------------------------------------------------------------------
module cfg_mgmt_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1023,
  parameter int GAP     = 2
) (
  input  logic                  user_clk,
  input  logic                  user_reset_n,
  input  logic                  user_lnk_up,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [10*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0]  req_func,
  input  logic [32*NUM_REQ-1:0] req_wdata,
  input  logic [4*NUM_REQ-1:0]  req_be,
  output logic [NUM_REQ-1:0]    req_done,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  cfg_mgmt_arbiter_if.master    cfg
);

  localparam int              IW        = $clog2(NUM_REQ);
  localparam logic [9:0]      TO_LAST   = 10'(TIMEOUT - 1);
  localparam logic [7:0]      GAP_LAST  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
  localparam logic [IW-1:0]   LAST_INIT = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    GAP_WAIT = 2'd2
  } state_t;

  state_t               state_r, state_nxt_s;
  logic                 rst_meta_r, rst_sync_n_r;
  logic [IW-1:0]        last_grant_r, grant_r, win_s, cand_s;
  logic                 win_valid_s;
  logic                 take_grant_s, done_match_s, timeout_s, gap_end_s;
  logic [9:0]           issue_cnt_r;
  logic [7:0]           gap_cnt_r;
  logic [9:0]           addr_r;
  logic [7:0]           func_r;
  logic [31:0]          wdata_r;
  logic [3:0]           be_r;
  logic                 write_r, cmd_wr_r, cmd_rd_r;
  logic [NUM_REQ-1:0]   req_done_r;
  logic [31:0]          rsp_data_r;
  logic                 rsp_err_r;

  // Reset synchronizer: assertion propagates at once, release follows two user_clk edges.
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      rst_meta_r   <= 1'b0;
      rst_sync_n_r <= 1'b0;
    end else begin
      rst_meta_r   <= 1'b1;
      rst_sync_n_r <= rst_meta_r;
    end
  end

  // Round-robin pick: first valid requester at or after last_grant+1, wrapping.
  always_comb begin
    win_s       = last_grant_r;
    win_valid_s = 1'b0;
    cand_s      = last_grant_r;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = IW'((int'(last_grant_r) + k) % NUM_REQ);
      if (!win_valid_s && req_valid[cand_s]) begin
        win_s       = cand_s;
        win_valid_s = 1'b1;
      end else begin
        win_valid_s = win_valid_s;
      end
    end
  end

  // FSM next-state and transition qualifiers.
  always_comb begin
    state_nxt_s  = state_r;
    take_grant_s = 1'b0;
    done_match_s = 1'b0;
    timeout_s    = 1'b0;
    gap_end_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (user_lnk_up && win_valid_s) begin
          take_grant_s = 1'b1;
          state_nxt_s  = ISSUE;
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      ISSUE: begin
        // Only the done type matching the outstanding command counts.
        done_match_s = write_r ? cfg.cfg2ctr_mgmt_write_done : cfg.cfg2ctr_mgmt_read_done;
        timeout_s    = !done_match_s && (issue_cnt_r == TO_LAST);
        if (done_match_s || timeout_s) begin
          state_nxt_s = GAP_WAIT;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      GAP_WAIT: begin
        gap_end_s = (gap_cnt_r == GAP_LAST);
        if (gap_end_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GAP_WAIT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge user_clk or negedge rst_sync_n_r) begin
    if (!rst_sync_n_r) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Grant capture, command strobes, counters and completion response.
  always_ff @(posedge user_clk or negedge rst_sync_n_r) begin
    if (!rst_sync_n_r) begin
      last_grant_r <= LAST_INIT;
      grant_r      <= {IW{1'b0}};
      issue_cnt_r  <= 10'd0;
      gap_cnt_r    <= 8'd0;
      addr_r       <= 10'd0;
      func_r       <= 8'd0;
      wdata_r      <= 32'd0;
      be_r         <= 4'd0;
      write_r      <= 1'b0;
      cmd_wr_r     <= 1'b0;
      cmd_rd_r     <= 1'b0;
      req_done_r   <= {NUM_REQ{1'b0}};
      rsp_data_r   <= 32'd0;
      rsp_err_r    <= 1'b0;
    end else begin
      req_done_r <= {NUM_REQ{1'b0}};
      case (state_r)
        IDLE: begin
          if (take_grant_s) begin
            grant_r      <= win_s;
            last_grant_r <= win_s;
            addr_r       <= req_addr[int'(win_s)*10 +: 10];
            func_r       <= req_func[int'(win_s)*8 +: 8];
            wdata_r      <= req_wdata[int'(win_s)*32 +: 32];
            be_r         <= req_be[int'(win_s)*4 +: 4];
            write_r      <= req_write[win_s];
            cmd_wr_r     <= req_write[win_s];
            cmd_rd_r     <= !req_write[win_s];
            issue_cnt_r  <= 10'd0;
          end
        end
        ISSUE: begin
          if (done_match_s || timeout_s) begin
            cmd_wr_r            <= 1'b0;
            cmd_rd_r            <= 1'b0;
            req_done_r[grant_r] <= 1'b1;
            rsp_data_r          <= timeout_s ? 32'hFFFF_FFFF :
                                   (write_r ? 32'd0 : cfg.cfg2ctr_mgmt_read_data);
            rsp_err_r           <= timeout_s;
            gap_cnt_r           <= 8'd0;
          end else begin
            issue_cnt_r <= issue_cnt_r + 10'd1;
          end
        end
        GAP_WAIT: gap_cnt_r <= gap_cnt_r + 8'd1;
        default:  gap_cnt_r <= 8'd0;
      endcase
    end
  end

  assign cfg.ctr2cfg_mgmt_addr            = addr_r;
  assign cfg.ctr2cfg_mgmt_function_number = func_r;
  assign cfg.ctr2cfg_mgmt_write           = cmd_wr_r;
  assign cfg.ctr2cfg_mgmt_write_data      = wdata_r;
  assign cfg.ctr2cfg_mgmt_byte_enable     = be_r;
  assign cfg.ctr2cfg_mgmt_read            = cmd_rd_r;
  assign cfg.ctr2cfg_mgmt_debug_access    = 1'b0;
  assign req_done = req_done_r;
  assign rsp_data = rsp_data_r;
  assign rsp_err  = rsp_err_r;

endmodule

// File: doc/cfg_mgmt_arbiter.md
CFG_MGMT_ARBITER -- requirements
Module: cfg_mgmt_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters (range 2..8).
REQ-002 Parameter TIMEOUT, default 1023, SHALL set the maximum cycles to wait for a done pulse (10-bit counter).
REQ-003 Parameter GAP, default 2, SHALL set the idle cycles between commands issued downstream.
REQ-004 user_clk  in  1  SHALL be the single clock; every flop is rising-edge.
REQ-005 user_reset_n  in  1  SHALL be an asynchronous, active-low reset.
REQ-006 user_lnk_up  in  1  SHALL gate new grants: no grant while low.
REQ-007 req_valid  in  NUM_REQ  SHALL be a per-requester request, held high until the matching req_done.
REQ-008 req_write  in  NUM_REQ  SHALL be per-requester: 1=write, 0=read.
REQ-009 req_addr  in  10*NUM_REQ, req_func in 8*NUM_REQ, req_wdata in 32*NUM_REQ, req_be in 4*NUM_REQ SHALL be packed per-requester fields; requester i occupies slice i.
REQ-010 req_done  out  NUM_REQ  SHALL be a one-cycle completion pulse to the granted requester.
REQ-011 rsp_data  out  32 / rsp_err  out  1  SHALL give read data and timeout status, valid in the req_done cycle.
REQ-012 ctr2cfg_mgmt_addr 10, ctr2cfg_mgmt_function_number 8, ctr2cfg_mgmt_write 1, ctr2cfg_mgmt_write_data 32, ctr2cfg_mgmt_byte_enable 4, ctr2cfg_mgmt_read 1, ctr2cfg_mgmt_debug_access 1  out  SHALL drive the configuration-bridge controller port.
REQ-013 cfg2ctr_mgmt_write_done 1, cfg2ctr_mgmt_read_done 1, cfg2ctr_mgmt_read_data 32  in  SHALL be the bridge completion inputs.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, GAP_WAIT.
REQ-015 In IDLE with user_lnk_up=1 and req_valid!=0, the arbiter SHALL grant round-robin: first set bit at or after (last_grant+1) mod NUM_REQ, then enter ISSUE on the next edge.
REQ-016 On grant, the arbiter SHALL register addr/func/wdata/be/write of the winner; downstream outputs SHALL be driven only from these registers.
REQ-017 In ISSUE, the arbiter SHALL hold ctr2cfg_mgmt_write (write) or ctr2cfg_mgmt_read (read) at 1 continuously; never both; debug_access SHALL be 0 always.
REQ-018 In ISSUE, the arbiter SHALL ignore a done pulse of the wrong type (a read_done during a write, and vice versa).
REQ-019 On a matching done in ISSUE, the arbiter SHALL, on the next edge, deassert write/read, pulse req_done[grant] for one cycle, set rsp_data=cfg2ctr_mgmt_read_data (reads) or 0 (writes), set rsp_err=0, and enter GAP_WAIT.
REQ-020 The ISSUE cycle counter SHALL start at 0 on entry; on reaching TIMEOUT without done, the arbiter SHALL deassert the command, pulse req_done[grant], set rsp_data=32'hFFFF_FFFF and rsp_err=1, and enter GAP_WAIT.
REQ-021 GAP_WAIT SHALL last exactly GAP cycles with all commands low, then return to IDLE, letting the bridge finish its DONE/IDLE return.
REQ-022 last_grant SHALL update only on grant; with a single persistent requester, that requester SHALL be regranted every transaction.
REQ-023 A req_valid drop during ISSUE SHALL NOT abort the transaction; req_done SHALL still pulse.
REQ-024 A user_lnk_up drop during ISSUE/GAP_WAIT SHALL NOT abort; it SHALL only block the next grant.
REQ-025 Latency from grant edge to command assertion SHALL be 1 cycle; minimum done-to-next-command spacing SHALL be GAP+2 cycles.

Reset
REQ-026 While user_reset_n=0, state SHALL be IDLE, and all outputs, registered fields and counters SHALL be 0; last_grant SHALL be NUM_REQ-1, so requester 0 has first priority.
REQ-027 An assertion of reset mid-transaction SHALL clear immediately with no req_done pulse; deassertion SHALL be synchronized internally to user_clk.

Verification
REQ-028 Stimulus: req_valid=4'b0001, read of addr 0x004, bridge returns 0x1234_5678 after 3 cycles -> response: one req_done[0] pulse, rsp_data=0x1234_5678, rsp_err=0.
REQ-029 Stimulus: req_valid=4'b1111, all writes held -> response: grants in order 0,1,2,3,0; each write_data/be forwarded unchanged.
REQ-030 Stimulus: write with no done for 1023 cycles -> response: command drops, req_done pulses, rsp_data=0xFFFF_FFFF, rsp_err=1, then GAP_WAIT.
REQ-031 Stimulus: write_done pulse injected during a read -> response: ignored, command stays high until read_done.
REQ-032 Stimulus: user_lnk_up=0 with req_valid=4'b0010 -> response: no command; grant occurs 1 cycle after user_lnk_up rises.
REQ-033 Stimulus: reset asserted mid-ISSUE -> response: ctr2cfg_mgmt_read/write=0 asynchronously, no req_done pulse, requester 0 granted first after release.
